// File: rtl/arb_pkg.sv
// +----------------------------------------------------------------------+
// | arb_pkg : shared constants, state type and round-robin search helper |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Returns {found, index} of the first set bit at or after ptr, wrapping mod 4.
    function automatic logic [IDX_W:0] rr_find_first(
        input logic [N_REQ-1:0] bits,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W:0]   result;
        logic [IDX_W-1:0] idx;
        result = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + IDX_W'(i);
            if (bits[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_enc4.sv
// +----------------------------------------------------------------------+
// | onehot_enc4 : 4-to-2 one-hot encoder, 2'b00 for any non-one-hot input |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module onehot_enc4 (
    input  logic [3:0] onehot,
    output logic [1:0] idx
);

    always_comb begin
        idx = 2'd0;
        case (onehot)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : 4-client round-robin arbiter with bounded hold time      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [CNT_W-1:0] c_max_hold   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_hold_one   = CNT_W'(1);
    localparam bit               c_preempt_en = (MAX_HOLD != 0);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_hold, w_hold_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic             r_preempt, w_preempt_nxt;

    logic [N_REQ-1:0] w_others;
    logic [N_REQ-1:0] w_search;
    logic [IDX_W:0]   w_find;
    logic             w_owner_req;
    logic             w_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_gnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_gnt     <= w_gnt_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_gnt_nxt     = r_gnt;
        w_preempt_nxt = 1'b0;
        w_take        = 1'b0;
        w_others      = req & ~r_gnt;
        w_owner_req   = |(req & r_gnt);
        w_search      = req;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_take = 1'b1;
                end
            end
            BUSY: begin
                if (!w_owner_req) begin
                    if (|req) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_hold_nxt  = '0;
                    end
                end else if (c_preempt_en && (r_hold == c_max_hold) && (|w_others)) begin
                    // Owner excluded from the search so the grant must rotate.
                    w_search      = w_others;
                    w_take        = 1'b1;
                    w_preempt_nxt = 1'b1;
                end else if (c_preempt_en && (r_hold != c_max_hold)) begin
                    w_hold_nxt = r_hold + c_hold_one;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_find = rr_find_first(w_search, r_ptr);

        if (w_take) begin
            w_state_nxt = BUSY;
            w_gnt_nxt   = N_REQ'(1) << w_find[IDX_W-1:0];
            w_ptr_nxt   = w_find[IDX_W-1:0] + IDX_W'(1);
            w_hold_nxt  = c_hold_one;
        end
    end

    onehot_enc4 u_enc (
        .onehot (r_gnt),
        .idx    (gnt_idx)
    );

    assign gnt       = r_gnt;
    assign gnt_valid = |r_gnt;
    assign preempt   = r_preempt;

endmodule

`default_nettype wire
